// File: rtl/nn_pkg.sv
// Shared types and helpers for the nn datapath blocks.
// Holds the scan FSM state type and a ceil-log2 helper.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/argmax_lane_cmp.sv
// Combinational LANES-to-1 max reduction over one scan pass.
// Lanes whose global index is past NUM_INPUT are masked out.
module argmax_lane_cmp
    import nn_pkg::*;
#(
    parameter int NUM_INPUT   = 10,
    parameter int INPUT_WIDTH = 16,
    parameter int LANES       = 1,
    parameter int SIGNED_MODE = 0,
    parameter int IDX_W       = clog2(NUM_INPUT)
) (
    input  logic [LANES*INPUT_WIDTH-1:0] i_lane_data,
    input  logic [31:0]                  i_base,
    output logic [INPUT_WIDTH-1:0]       o_val,
    output logic [IDX_W-1:0]             o_idx,
    output logic                         o_any
);

    function automatic logic gt(
        input logic [INPUT_WIDTH-1:0] a,
        input logic [INPUT_WIDTH-1:0] b
    );
        if (SIGNED_MODE != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    logic [INPUT_WIDTH-1:0] best_val;
    logic [IDX_W-1:0]       best_idx;
    logic                   best_any;

    // Strict greater-than keeps the lowest lane on ties.
    always_comb begin
        best_val = '0;
        best_idx = '0;
        best_any = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if ((i_base + 32'(l)) < 32'(NUM_INPUT)) begin
                if (!best_any ||
                    gt(i_lane_data[l*INPUT_WIDTH +: INPUT_WIDTH], best_val)) begin
                    best_val = i_lane_data[l*INPUT_WIDTH +: INPUT_WIDTH];
                    best_idx = IDX_W'(i_base + 32'(l));
                    best_any = 1'b1;
                end
            end
        end
    end

    assign o_val = best_val;
    assign o_idx = best_idx;
    assign o_any = best_any;

endmodule

// File: rtl/argmax_engine.sv
// Multi-cycle argmax over a NUM_INPUT vector, LANES elements per cycle.
// Result is held in DONE until the consumer raises i_ready.
module argmax_engine
    import nn_pkg::*;
#(
    parameter int NUM_INPUT   = 10,
    parameter int INPUT_WIDTH = 16,
    parameter int LANES       = 1,
    parameter int SIGNED_MODE = 0
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_INPUT*INPUT_WIDTH-1:0] i_data,
    input  logic                             i_valid,
    output logic                             o_ready,
    output logic [31:0]                      o_index,
    output logic [INPUT_WIDTH-1:0]           o_max,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic                             o_busy
);

    localparam int P    = (NUM_INPUT + LANES - 1) / LANES;
    localparam int CW   = clog2(P) + 1;
    localparam int IW   = clog2(NUM_INPUT);
    localparam int PADW = P * LANES * INPUT_WIDTH;

    state_e                           state_q, state_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic [NUM_INPUT*INPUT_WIDTH-1:0] buf_q, buf_d;
    logic [INPUT_WIDTH-1:0]           max_q, max_d;
    logic [IW-1:0]                    idx_q, idx_d;
    logic                             vld_q, vld_d;

    logic [PADW-1:0]              buf_pad;
    logic [LANES*INPUT_WIDTH-1:0] lane_data;
    logic [31:0]                  base;
    logic [INPUT_WIDTH-1:0]       cmp_val;
    logic [IW-1:0]                cmp_idx;
    logic                         cmp_any;

    function automatic logic gt(
        input logic [INPUT_WIDTH-1:0] a,
        input logic [INPUT_WIDTH-1:0] b
    );
        if (SIGNED_MODE != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    // Zero padding lets the last, partially filled pass use a fixed slice.
    assign buf_pad = PADW'(buf_q);
    assign base    = 32'(cnt_q) * 32'(LANES);

    always_comb begin
        lane_data = '0;
        for (int p = 0; p < P; p++) begin
            if (cnt_q == CW'(p)) begin
                lane_data = buf_pad[p*LANES*INPUT_WIDTH +: LANES*INPUT_WIDTH];
            end
        end
    end

    argmax_lane_cmp #(
        .NUM_INPUT  (NUM_INPUT),
        .INPUT_WIDTH(INPUT_WIDTH),
        .LANES      (LANES),
        .SIGNED_MODE(SIGNED_MODE),
        .IDX_W      (IW)
    ) u_cmp (
        .i_lane_data(lane_data),
        .i_base     (base),
        .o_val      (cmp_val),
        .o_idx      (cmp_idx),
        .o_any      (cmp_any)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        max_d   = max_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    buf_d   = i_data;
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // First pass seeds the running max; later passes need a strict win.
                if (cmp_any && (cnt_q == '0 || gt(cmp_val, max_q))) begin
                    max_d = cmp_val;
                    idx_d = cmp_idx;
                end
                if (cnt_q == CW'(P - 1)) begin
                    cnt_d   = '0;
                    vld_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (i_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

    assign o_ready = (state_q == IDLE) && i_rst_n;
    assign o_busy  = (state_q != IDLE);
    assign o_valid = vld_q;
    assign o_index = 32'(idx_q);
    assign o_max   = max_q;

endmodule

// File: doc/argmax_engine.md
ARGMAX_ENGINE -- requirements
Module: argmax_engine

Interface
REQ-001 The block SHALL have parameter NUM_INPUT, default 10, meaning the number of elements per vector (at least 2).
REQ-002 The block SHALL have parameter INPUT_WIDTH, default 16, meaning the bit width of each element.
REQ-003 The block SHALL have parameter LANES, default 1, meaning the number of elements compared per cycle (1 to NUM_INPUT).
REQ-004 The block SHALL have parameter SIGNED_MODE, default 0, where 1 selects two's-complement compare and 0 selects unsigned compare.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port i_data, input, NUM_INPUT*INPUT_WIDTH bits: element k at bits [k*INPUT_WIDTH +: INPUT_WIDTH].
REQ-008 The block SHALL have port i_valid, input, 1 bit: the input vector is valid.
REQ-009 The block SHALL have port o_ready, output, 1 bit: the block can accept a vector.
REQ-010 The block SHALL have port o_index, output, 32 bits: the index of the maximum element, zero-extended.
REQ-011 The block SHALL have port o_max, output, INPUT_WIDTH bits: the maximum element value.
REQ-012 The block SHALL have port o_valid, output, 1 bit: o_index and o_max are valid.
REQ-013 The block SHALL have port i_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-014 The block SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement the states IDLE, SCAN and DONE; o_ready SHALL be high only in IDLE.
REQ-016 The block SHALL accept a vector when i_valid and o_ready are both high (cycle T), register i_data into an internal buffer, and move to SCAN.
REQ-017 The block SHALL ignore i_valid in SCAN and DONE; the buffer SHALL not change until the next accept.
REQ-018 The block SHALL perform P = ceil(NUM_INPUT/LANES) scan passes in cycles T+1 to T+P, with pass p covering elements p*LANES to p*LANES+LANES-1.
REQ-019 Lanes with an index of NUM_INPUT or higher SHALL be masked and SHALL never win a compare.
REQ-020 Each pass SHALL reduce its lanes to one (value, index) candidate and update the running max only when the candidate is strictly greater.
REQ-021 Ties SHALL resolve to the lowest index, both inside a pass and across passes.
REQ-022 The first pass SHALL load its candidate into the running max unconditionally, so no sentinel value is used.
REQ-023 The block SHALL enter DONE at T+P+1, and o_valid, o_index and o_max SHALL be driven from registers in that same cycle.
REQ-024 In DONE, the outputs SHALL hold stable while i_ready is low; when i_ready is high, the block SHALL return to IDLE on the next cycle with o_valid low.
REQ-025 If i_ready is already high on entry to DONE, the result SHALL be transferred in that cycle and o_valid SHALL stay high for exactly 1 cycle.
REQ-026 Total latency from accept to o_valid SHALL be P+1 cycles; sustained throughput SHALL be 1 vector per P+2 cycles.
REQ-027 Compares SHALL use $signed operands when SIGNED_MODE=1 and unsigned operands otherwise; o_max SHALL return the raw bits.
REQ-028 The pass counter width SHALL be clog2(P)+1 and the index width SHALL be clog2(NUM_INPUT), zero-extended to 32 bits on o_index.

Reset
REQ-029 While i_rst_n is low at a clock edge, the block SHALL go to IDLE and set o_valid=0, o_busy=0, o_index=0, o_max=0, the counter to 0 and the running max to 0.
REQ-030 o_ready SHALL be 0 during any cycle in which i_rst_n is low, and 1 on the first cycle after release.
REQ-031 A reset during SCAN or DONE SHALL abort the operation, discard the result, and produce no o_valid pulse after reset.

Structure
REQ-032 A shared package nn_pkg SHALL hold a clog2 helper function and the state enum type (IDLE, SCAN, DONE).
REQ-033 The block SHALL contain one sub-module, argmax_lane_cmp: a combinational LANES-to-1 reduction tree that returns the winning value, its index and an any-valid flag, with masking and signedness as parameters.

Verification
REQ-034 With N=10, W=16, L=1, unsigned, inputs 0..9 = 3,1,4,1,5,9,2,6,5,3 accepted at T, the bench SHALL see o_valid at T+11 with o_index=5 and o_max=9.
REQ-035 With inputs 2 and 5 both 0x7FFF and all others smaller, the bench SHALL see o_index=2 for L=1, L=4 and L=10.
REQ-036 With element 0 = 0x8000, element 3 = 0x0001 and all others 0x0000, SIGNED_MODE=1 SHALL give o_index=3, o_max=0x0001, and SIGNED_MODE=0 SHALL give o_index=0, o_max=0x8000.
REQ-037 With N=10, L=4 and the maximum at index 9 (in a partially masked pass), the bench SHALL see o_valid at T+4 with o_index=9.
REQ-038 With i_ready held low for 5 cycles in DONE and i_valid pulsed during that time, the outputs SHALL stay stable, o_ready SHALL stay 0 and the new vector SHALL be ignored; after i_ready rises, the block SHALL return to IDLE with o_ready=1.
REQ-039 With i_rst_n low for 1 cycle at T+3 of a scan, all outputs SHALL be 0 and o_valid SHALL never assert; the next accepted vector SHALL produce the correct result.
